// File: rtl/r5fp_sig_divsqrt_seq.sv
// Radix-2 restoring significand divider / square-root engine for the R5FP datapath.
// Produces one result bit per cycle and returns a truncated significand, a sticky bit and divide-by-zero.
module r5fp_sig_divsqrt_seq #(
    parameter int SIG_W = 23,
    parameter int Q_W   = SIG_W + 3,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             strobe_in,
    input  logic             sqrt_in,
    input  logic             odd_in,
    input  logic [SIG_W:0]   a_sig_in,
    input  logic [SIG_W:0]   b_sig_in,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             kill_in,
    output logic             ready_out,
    output logic             valid_out,
    output logic [Q_W-1:0]   q_out,
    output logic             sticky_out,
    output logic             dz_out,
    output logic [TAG_W-1:0] tag_out
);
    // state | meaning
    // IDLE  | waiting for a strobe
    // ITER  | one result bit per cycle, cnt = 0..Q_W-1
    // DONE  | result valid for one cycle; a new strobe may be accepted
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    // Sqrt needs Q_W+3 bits of remainder; divide needs only SIG_W+3, so one register serves both.
    localparam int REM_W = Q_W + 3;
    localparam int CNT_W = $clog2(Q_W);
    localparam int SH    = 2 * Q_W - 2 - SIG_W;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sqrt_q, sqrt_d;
    logic               dz_q, dz_d;
    logic [SIG_W:0]     b_q, b_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [2*Q_W-1:0]   rad_q, rad_d;
    logic [Q_W-1:0]     root_q, root_d;
    logic [Q_W-1:0]     q_out_q, q_out_d;
    logic               sticky_q, sticky_d;
    logic               dz_out_q, dz_out_d;
    logic [TAG_W-1:0]   tag_out_q, tag_out_d;

    logic               accept;
    logic [SIG_W+1:0]   rad_init;
    logic [REM_W-1:0]   rem_sh;
    logic [REM_W:0]     sq_diff;
    logic [REM_W:0]     div_diff;
    logic               bit_new;
    logic [REM_W-1:0]   rem_next;
    logic [Q_W-1:0]     root_next;

    assign ready_out  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign valid_out  = (state_q == S_DONE);
    assign q_out      = q_out_q;
    assign sticky_out = sticky_q;
    assign dz_out     = dz_out_q;
    assign tag_out    = tag_out_q;

    assign accept   = strobe_in && ready_out && !kill_in;
    assign rad_init = odd_in ? {a_sig_in, 1'b0} : {1'b0, a_sig_in};

    // Sqrt brings down two radicand bits per step and tries 4*root+1.
    always_comb begin
        rem_sh   = {rem_q[REM_W-3:0], rad_q[2*Q_W-1 -: 2]};
        sq_diff  = {1'b0, rem_sh} - {1'b0, REM_W'({root_q, 2'b01})};
        div_diff = {1'b0, rem_q} - (REM_W+1)'(b_q);
        if (sqrt_q) begin
            bit_new  = !sq_diff[REM_W];
            rem_next = bit_new ? sq_diff[REM_W-1:0] : rem_sh;
        end else begin
            bit_new  = !div_diff[REM_W];
            rem_next = bit_new ? {div_diff[REM_W-2:0], 1'b0} : {rem_q[REM_W-2:0], 1'b0};
        end
        root_next = {root_q[Q_W-2:0], bit_new};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sqrt_d    = sqrt_q;
        dz_d      = dz_q;
        b_d       = b_q;
        tag_d     = tag_q;
        rem_d     = rem_q;
        rad_d     = rad_q;
        root_d    = root_q;
        q_out_d   = q_out_q;
        sticky_d  = sticky_q;
        dz_out_d  = dz_out_q;
        tag_out_d = tag_out_q;
        case (state_q)
            S_ITER: begin
                if (kill_in) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    rem_d  = rem_next;
                    root_d = root_next;
                    rad_d  = {rad_q[2*Q_W-3:0], 2'b00};
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(Q_W - 1)) begin
                        state_d   = S_DONE;
                        cnt_d     = '0;
                        q_out_d   = dz_q ? '1 : root_next;
                        sticky_d  = dz_q || (rem_next != '0);
                        dz_out_d  = dz_q;
                        tag_out_d = tag_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            state_d = S_ITER;
            cnt_d   = '0;
            sqrt_d  = sqrt_in;
            dz_d    = !sqrt_in && !b_sig_in[SIG_W];
            b_d     = b_sig_in;
            tag_d   = tag_in;
            rem_d   = sqrt_in ? '0 : REM_W'(a_sig_in);
            rad_d   = {rad_init, {SH{1'b0}}};
            root_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sqrt_q    <= 1'b0;
            dz_q      <= 1'b0;
            b_q       <= '0;
            tag_q     <= '0;
            rem_q     <= '0;
            rad_q     <= '0;
            root_q    <= '0;
            q_out_q   <= '0;
            sticky_q  <= 1'b0;
            dz_out_q  <= 1'b0;
            tag_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sqrt_q    <= sqrt_d;
            dz_q      <= dz_d;
            b_q       <= b_d;
            tag_q     <= tag_d;
            rem_q     <= rem_d;
            rad_q     <= rad_d;
            root_q    <= root_d;
            q_out_q   <= q_out_d;
            sticky_q  <= sticky_d;
            dz_out_q  <= dz_out_d;
            tag_out_q <= tag_out_d;
        end
    end
endmodule

// File: tb/tb_r5fp_sig_divsqrt_seq.sv
// Self-checking bench for r5fp_sig_divsqrt_seq against an arithmetic reference model.
module tb_r5fp_sig_divsqrt_seq;
    localparam int SIG_W = 23;
    localparam int Q_W   = SIG_W + 3;
    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             strobe_in = 1'b0;
    logic             sqrt_in = 1'b0;
    logic             odd_in = 1'b0;
    logic [SIG_W:0]   a_sig_in = '0;
    logic [SIG_W:0]   b_sig_in = '0;
    logic [TAG_W-1:0] tag_in = '0;
    logic             kill_in = 1'b0;
    logic             ready_out, valid_out, sticky_out, dz_out;
    logic [Q_W-1:0]   q_out;
    logic [TAG_W-1:0] tag_out;

    int checks = 0;
    int errors = 0;

    r5fp_sig_divsqrt_seq #(.SIG_W(SIG_W), .Q_W(Q_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .strobe_in(strobe_in), .sqrt_in(sqrt_in),
        .odd_in(odd_in), .a_sig_in(a_sig_in), .b_sig_in(b_sig_in), .tag_in(tag_in),
        .kill_in(kill_in), .ready_out(ready_out), .valid_out(valid_out), .q_out(q_out),
        .sticky_out(sticky_out), .dz_out(dz_out), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact rational/integer results, no bit recurrence.
    task automatic model(input bit sq, input bit od, input logic [SIG_W:0] a, input logic [SIG_W:0] b,
                         output logic [Q_W-1:0] q, output bit st, output bit dz);
        longint unsigned num, r, n;
        dz = !sq && !b[SIG_W];
        if (dz) begin
            q  = '1;
            st = 1'b1;
        end else if (!sq) begin
            num = longint'(a) << (Q_W - 1);
            q   = Q_W'(num / longint'(b));
            st  = (num % longint'(b)) != 0;
        end else begin
            n = (od ? (longint'(a) << 1) : longint'(a)) << (2 * Q_W - 2 - SIG_W);
            r = longint'($floor($sqrt(real'(n))));
            while (r * r > n) r--;
            while ((r + 1) * (r + 1) <= n) r++;
            q  = Q_W'(r);
            st = (r * r) != n;
        end
    endtask

    task automatic drive_op(input bit sq, input bit od, input logic [SIG_W:0] a,
                            input logic [SIG_W:0] b, input logic [TAG_W-1:0] tg);
        strobe_in = 1'b1;
        sqrt_in   = sq;
        odd_in    = od;
        a_sig_in  = a;
        b_sig_in  = b;
        tag_in    = tg;
    endtask

    task automatic check_result(input string nm, input bit sq, input bit od, input logic [SIG_W:0] a,
                                input logic [SIG_W:0] b, input logic [TAG_W-1:0] tg);
        logic [Q_W-1:0] eq;
        bit es, ed;
        model(sq, od, a, b, eq, es, ed);
        chk({nm, "_q"}, 64'(q_out), 64'(eq));
        chk({nm, "_sticky"}, 64'(sticky_out), 64'(es));
        chk({nm, "_dz"}, 64'(dz_out), 64'(ed));
        chk({nm, "_tag"}, 64'(tag_out), 64'(tg));
    endtask

    // Starts one op from IDLE and waits for its result; hold keeps strobe high mid-ITER.
    task automatic run_op(input string nm, input bit sq, input bit od, input logic [SIG_W:0] a,
                          input logic [SIG_W:0] b, input logic [TAG_W-1:0] tg, input bit hold);
        int lat;
        lat = 0;
        @(negedge clk);
        drive_op(sq, od, a, b, tg);
        @(posedge clk);
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (valid_out) begin
                lat = i;
                break;
            end
            if (i == 1) begin
                a_sig_in = SIG_W'($urandom);
                b_sig_in = SIG_W'($urandom);
                tag_in   = TAG_W'($urandom);
                sqrt_in  = $urandom_range(0, 1);
            end
            if (!hold || i == 20) strobe_in = 1'b0;
        end
        chk({nm, "_latency"}, 64'(lat), 64'(Q_W + 1));
        if (lat != 0) check_result(nm, sq, od, a, b, tg);
        @(negedge clk);
        chk({nm, "_pulse_len"}, 64'(valid_out), 64'd0);
    endtask

    logic [Q_W-1:0] eq;
    bit es, ed;
    int t1, t2, pulses;

    initial begin
        #1;
        chk("reset_q", 64'(q_out), 64'd0);
        chk("reset_valid", 64'(valid_out), 64'd0);
        chk("reset_ready", 64'(ready_out), 64'd1);
        chk("reset_misc", 64'({sticky_out, dz_out, tag_out}), 64'd0);
        #22 rst_n = 1'b1;

        run_op("div_1_1", 0, 0, 24'h800000, 24'h800000, 8'h11, 0);
        chk("div_1_1_const", 64'({q_out, sticky_out}), 64'({26'h2000000, 1'b0}));
        run_op("div_1_15", 0, 0, 24'h800000, 24'hC00000, 8'h12, 0);
        chk("div_1_15_const", 64'({q_out, sticky_out}), 64'({26'h1555555, 1'b1}));
        run_op("sqrt_1", 1, 0, 24'h800000, 24'h000000, 8'h13, 0);
        chk("sqrt_1_const", 64'({q_out, sticky_out}), 64'({26'h2000000, 1'b0}));
        run_op("sqrt_2", 1, 1, 24'h800000, 24'h000000, 8'h14, 0);
        chk("sqrt_2_const", 64'({q_out, sticky_out}), 64'({26'h2D413CC, 1'b1}));
        run_op("sqrt_225", 1, 1, 24'h900000, 24'h000000, 8'h15, 1);
        chk("sqrt_225_const", 64'({q_out, sticky_out}), 64'({26'h3000000, 1'b0}));
        run_op("div_zero", 0, 0, 24'hA12345, 24'h000000, 8'h5A, 0);
        chk("div_zero_const", 64'({q_out, sticky_out, dz_out, tag_out}),
            64'({26'h3FFFFFF, 1'b1, 1'b1, 8'h5A}));

        for (int k = 0; k < 24; k++) begin
            logic [SIG_W:0] ra, rb;
            ra = {1'b1, SIG_W'($urandom)};
            rb = {($urandom_range(0, 7) != 0), SIG_W'($urandom)};
            run_op("rand", $urandom_range(0, 1), $urandom_range(0, 1), ra, rb,
                   TAG_W'($urandom), $urandom_range(0, 1));
        end

        // Back-to-back with strobe held: second op accepted in the DONE cycle.
        @(negedge clk);
        drive_op(0, 0, 24'hF00000, 24'h900000, 8'h01);
        @(posedge clk);
        @(negedge clk);
        drive_op(0, 0, 24'h812345, 24'hFEDCBA, 8'h02);
        t1 = 0;
        t2 = 0;
        for (int i = 1; i <= 80; i++) begin
            if (i > 1) @(negedge clk);
            if (valid_out && t1 == 0) begin
                t1 = i;
                chk("b2b_ready_in_done", 64'(ready_out), 64'd1);
                check_result("b2b_op1", 0, 0, 24'hF00000, 24'h900000, 8'h01);
            end else if (valid_out) begin
                t2 = i;
                check_result("b2b_op2", 0, 0, 24'h812345, 24'hFEDCBA, 8'h02);
                break;
            end else if (t1 != 0) begin
                strobe_in = 1'b0;
            end
        end
        chk("b2b_first_latency", 64'(t1), 64'(Q_W + 1));
        chk("b2b_spacing", 64'(t2 - t1), 64'(Q_W + 1));

        // Kill at cnt==10: no result, then a fresh op completes normally.
        @(negedge clk);
        drive_op(1, 1, 24'hC00000, 24'h0, 8'h33);
        @(posedge clk);
        @(negedge clk);
        strobe_in = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        kill_in = 1'b1;
        @(negedge clk);
        kill_in = 1'b0;
        chk("kill_ready", 64'(ready_out), 64'd1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_out) pulses++;
            @(negedge clk);
        end
        chk("kill_no_valid", 64'(pulses), 64'd0);
        run_op("after_kill", 0, 0, 24'hC00000, 24'hA00000, 8'h44, 0);

        // Async reset mid-ITER clears every output immediately.
        @(negedge clk);
        drive_op(0, 0, 24'hFFFFFF, 24'h800001, 8'h77);
        @(posedge clk);
        @(negedge clk);
        strobe_in = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", 64'({q_out, sticky_out, dz_out, tag_out, valid_out}), 64'd0);
        chk("rst_mid_ready", 64'(ready_out), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        model(0, 0, 24'h900000, 24'hB00000, eq, es, ed);
        run_op("after_rst", 0, 0, 24'h900000, 24'hB00000, 8'h66, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
